// File: rtl/eq_vote_tracker_if.sv
// Handshake and result bundle between the equality stage consumer and its
// neighbours: upstream valid/ready with the 25-bit equality vector, and
// downstream valid/ready with the per-sample statistics.
interface eq_vote_tracker_if #(
  parameter int STREAK_W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [24:0]         eq_vec;
  logic                out_valid;
  logic                out_ready;
  logic [4:0]          match_count;
  logic [2:0]          row0_agree;
  logic                consistent;
  logic                unanimous;
  logic [STREAK_W-1:0] streak;
  logic                alarm;

  // Producer/consumer side: drives the vector and accepts the statistics.
  modport master (
    output in_valid, eq_vec, out_ready,
    input  in_ready, out_valid, match_count, row0_agree,
           consistent, unanimous, streak, alarm
  );

  // Tracker side.
  modport slave (
    input  in_valid, eq_vec, out_ready,
    output in_ready, out_valid, match_count, row0_agree,
           consistent, unanimous, streak, alarm
  );
endinterface

// File: rtl/eq_vote_tracker.sv
// Two-stage valid/ready tracker for the 5x5 pairwise-equality vector.
// Stage 1 captures the raw vector; stage 2 holds the registered statistics
// (popcounts, consistency, unanimity) plus a saturating streak of
// consecutive unanimous samples and a threshold alarm.
// Vector bit mapping: eq_vec[24-(5*i+j)] = (x_i == x_j), i,j in 0..4.
module eq_vote_tracker #(
  parameter int STREAK_W = 8,
  parameter int THRESH   = 4
) (
  input logic             clk,
  input logic             resetn,
  input logic             clear,
  eq_vote_tracker_if.slave bus
);

  // Diagonal positions (x_i == x_i) are bits 24, 18, 12, 6 and 0.
  localparam logic [24:0]         DIAG_MASK  = 25'b10000_01000_00100_00010_00001;
  localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};
  localparam logic [STREAK_W-1:0] THRESH_V   = STREAK_W'(THRESH);

  logic                adv;
  logic                s1_valid;
  logic [24:0]         s1_vec;
  logic [24:0]         s1_vec_t;
  logic [4:0]          mc_next;
  logic [2:0]          row0_next;
  logic                cons_next;
  logic                unan_next;
  logic [STREAK_W-1:0] streak_next;
  logic                alarm_next;

  logic                out_valid_q;
  logic [4:0]          match_count_q;
  logic [2:0]          row0_q;
  logic                cons_q;
  logic                unan_q;
  logic [STREAK_W-1:0] streak_q;
  logic                alarm_q;

  // The whole pipe moves whenever the output slot is empty or being drained,
  // so in_ready depends only on registered state and out_ready.
  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid   = out_valid_q;
  assign bus.match_count = match_count_q;
  assign bus.row0_agree  = row0_q;
  assign bus.consistent  = cons_q;
  assign bus.unanimous   = unan_q;
  assign bus.streak      = streak_q;
  assign bus.alarm       = alarm_q;

  // Transpose the 5x5 equality matrix so symmetry becomes a plain compare.
  always_comb begin
    s1_vec_t = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        s1_vec_t[24-(5*j+i)] = s1_vec[24-(5*i+j)];
      end
    end
  end

  // Statistics and next streak/alarm for the sample sitting in stage 1.
  always_comb begin
    mc_next   = '0;
    row0_next = '0;
    for (int k = 0; k < 25; k++) begin
      mc_next = mc_next + {4'b0000, s1_vec[k]};
    end
    for (int k = 20; k < 25; k++) begin
      row0_next = row0_next + {2'b00, s1_vec[k]};
    end
    cons_next = ((s1_vec & DIAG_MASK) == DIAG_MASK) && (s1_vec == s1_vec_t);
    unan_next = cons_next && (&s1_vec[24:20]);
    if (!unan_next) begin
      streak_next = '0;
    end else if (streak_q == STREAK_MAX) begin
      streak_next = STREAK_MAX;
    end else begin
      streak_next = streak_q + 1'b1;
    end
    alarm_next = (streak_next >= THRESH_V);
  end

  // Stage 1: capture the incoming vector; clear drops whatever is presented.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_vec   <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= bus.in_valid && adv;
      s1_vec   <= bus.eq_vec;
    end
  end

  // Stage 2: registered outputs; bubbles advance without touching the streak.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q   <= 1'b0;
      match_count_q <= '0;
      row0_q        <= '0;
      cons_q        <= 1'b0;
      unan_q        <= 1'b0;
      streak_q      <= '0;
      alarm_q       <= 1'b0;
    end else if (clear) begin
      out_valid_q <= 1'b0;
      streak_q    <= '0;
      alarm_q     <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        match_count_q <= mc_next;
        row0_q        <= row0_next;
        cons_q        <= cons_next;
        unan_q        <= unan_next;
        streak_q      <= streak_next;
        alarm_q       <= alarm_next;
      end
    end
  end

endmodule

// File: tb/tb_eq_vote_tracker.sv
// Bench for eq_vote_tracker: two instances (8-bit and 3-bit streak) share
// one stimulus stream and are compared every cycle against a behavioural
// model that derives statistics from the equality matrix and the streak
// from the run length of unanimous deliveries. Directed sequences add
// hand-computed literal expectations on top of the model.
module tb_eq_vote_tracker;

  localparam int THRESH = 4;

  logic        clk       = 1'b0;
  logic        resetn    = 1'b0;
  logic        clear     = 1'b0;
  logic        in_valid  = 1'b0;
  logic [24:0] eq_vec    = '0;
  logic        out_ready = 1'b1;

  int n_total = 0;
  int n_pass  = 0;

  // Literal expectations for the next compare point; -1 means don't care.
  bit lit_en = 1'b0;
  int lit_mc, lit_r0, lit_co, lit_un, lit_s8, lit_a8, lit_s3, lit_ov, lit_ir;

  // Model state: occupancy of the two slots and the unanimous run length.
  bit          m_s1v  = 1'b0;
  bit          m_ov   = 1'b0;
  logic [24:0] m_s1vec = '0;
  logic [24:0] m_ovec  = '0;
  int          m_run  = 0;

  int e_mc, e_r0, e_co, e_un, e_s8, e_s3;

  eq_vote_tracker_if #(.STREAK_W(8)) bus8 ();
  eq_vote_tracker_if #(.STREAK_W(3)) bus3 ();

  assign bus8.in_valid  = in_valid;
  assign bus8.eq_vec    = eq_vec;
  assign bus8.out_ready = out_ready;
  assign bus3.in_valid  = in_valid;
  assign bus3.eq_vec    = eq_vec;
  assign bus3.out_ready = out_ready;

  eq_vote_tracker #(.STREAK_W(8), .THRESH(THRESH)) dut8 (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .bus    (bus8.slave)
  );

  eq_vote_tracker #(.STREAK_W(3), .THRESH(THRESH)) dut3 (
    .clk    (clk),
    .resetn (resetn),
    .clear  (clear),
    .bus    (bus3.slave)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic bit eq_bit(input logic [24:0] v, input int i, input int j);
    return v[24-(5*i+j)];
  endfunction

  // Statistics straight from the matrix definition.
  function automatic void stats(input logic [24:0] v, output int mc, output int r0,
                                output int co, output int un);
    mc = 0;
    r0 = 0;
    co = 1;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        mc += int'(eq_bit(v, i, j));
        if (i == 0) r0 += int'(eq_bit(v, i, j));
        if (i == j && !eq_bit(v, i, j)) co = 0;
        if (i < j && eq_bit(v, i, j) != eq_bit(v, j, i)) co = 0;
      end
    un = (co == 1 && r0 == 5) ? 1 : 0;
  endfunction

  function automatic int sat(input int run, input int maxv);
    return (run > maxv) ? maxv : run;
  endfunction

  // Mix of unanimous, self-consistent (real a..e values) and arbitrary vectors.
  function automatic logic [24:0] rand_vec();
    int kind;
    int x[5];
    logic [24:0] v;
    kind = $urandom_range(0, 9);
    v = '1;
    if (kind >= 4 && kind < 7) begin
      for (int i = 0; i < 5; i++) x[i] = $urandom_range(0, 2);
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) v[24-(5*i+j)] = (x[i] == x[j]);
    end else if (kind >= 7) begin
      v = 25'($urandom);
    end
    return v;
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic apply_stimulus(input logic iv, input logic [24:0] v,
                                input logic ordy, input logic clr);
    @(posedge clk);
    #2;
    in_valid  = iv;
    eq_vec    = v;
    out_ready = ordy;
    clear     = clr;
    lit_en    = 1'b0;
  endtask

  task automatic set_lit(input int mc, input int r0, input int co, input int un,
                         input int s8, input int a8, input int s3, input int ov,
                         input int ir);
    lit_mc = mc; lit_r0 = r0; lit_co = co; lit_un = un;
    lit_s8 = s8; lit_a8 = a8; lit_s3 = s3; lit_ov = ov; lit_ir = ir;
    lit_en = 1'b1;
  endtask

  // Behavioural model: slot occupancy plus run length of unanimous deliveries.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_s1v   <= 1'b0;
      m_s1vec <= '0;
      m_ov    <= 1'b0;
      m_ovec  <= '0;
      m_run   <= 0;
    end else if (clear) begin
      m_s1v <= 1'b0;
      m_ov  <= 1'b0;
      m_run <= 0;
    end else if (!m_ov || out_ready) begin
      m_s1v   <= in_valid;
      m_s1vec <= eq_vec;
      m_ov    <= m_s1v;
      if (m_s1v) begin
        int mc, r0, co, un;
        stats(m_s1vec, mc, r0, co, un);
        m_ovec <= m_s1vec;
        m_run  <= (un == 1) ? m_run + 1 : 0;
      end
    end
  end

  // Single compare point, just after each falling clock edge or reset assertion.
  always begin
    @(negedge clk or negedge resetn);
    #1;
    if (!resetn) begin
      check_output("rst.out_valid",   int'(bus8.out_valid),   0);
      check_output("rst.match_count", int'(bus8.match_count), 0);
      check_output("rst.row0_agree",  int'(bus8.row0_agree),  0);
      check_output("rst.consistent",  int'(bus8.consistent),  0);
      check_output("rst.unanimous",   int'(bus8.unanimous),   0);
      check_output("rst.streak",      int'(bus8.streak),      0);
      check_output("rst.alarm",       int'(bus8.alarm),       0);
      check_output("rst.out_valid3",  int'(bus3.out_valid),   0);
      check_output("rst.streak3",     int'(bus3.streak),      0);
    end else begin
      stats(m_ovec, e_mc, e_r0, e_co, e_un);
      e_s8 = sat(m_run, 255);
      e_s3 = sat(m_run, 7);
      check_output("out_valid",  int'(bus8.out_valid), int'(m_ov));
      check_output("out_valid3", int'(bus3.out_valid), int'(m_ov));
      check_output("in_ready",   int'(bus8.in_ready),  int'(!m_ov || out_ready));
      check_output("in_ready3",  int'(bus3.in_ready),  int'(!m_ov || out_ready));
      check_output("streak",     int'(bus8.streak),    e_s8);
      check_output("alarm",      int'(bus8.alarm),     int'(e_s8 >= THRESH));
      check_output("streak3",    int'(bus3.streak),    e_s3);
      check_output("alarm3",     int'(bus3.alarm),     int'(e_s3 >= THRESH));
      if (m_ov) begin
        check_output("match_count", int'(bus8.match_count), e_mc);
        check_output("row0_agree",  int'(bus8.row0_agree),  e_r0);
        check_output("consistent",  int'(bus8.consistent),  e_co);
        check_output("unanimous",   int'(bus8.unanimous),   e_un);
        check_output("match_count3", int'(bus3.match_count), e_mc);
        check_output("unanimous3",   int'(bus3.unanimous),   e_un);
      end
      if (lit_en) begin
        if (lit_mc >= 0) check_output("lit.match_count", int'(bus8.match_count), lit_mc);
        if (lit_r0 >= 0) check_output("lit.row0_agree",  int'(bus8.row0_agree),  lit_r0);
        if (lit_co >= 0) check_output("lit.consistent",  int'(bus8.consistent),  lit_co);
        if (lit_un >= 0) check_output("lit.unanimous",   int'(bus8.unanimous),   lit_un);
        if (lit_s8 >= 0) check_output("lit.streak",      int'(bus8.streak),      lit_s8);
        if (lit_a8 >= 0) check_output("lit.alarm",       int'(bus8.alarm),       lit_a8);
        if (lit_s3 >= 0) check_output("lit.streak3",     int'(bus3.streak),      lit_s3);
        if (lit_ov >= 0) check_output("lit.out_valid",   int'(bus8.out_valid),   lit_ov);
        if (lit_ir >= 0) check_output("lit.in_ready",    int'(bus8.in_ready),    lit_ir);
      end
    end
  end

  // Directed sequences followed by a randomized stream.
  initial begin
    logic [24:0] v_mixed;
    logic [24:0] v_nodiag;
    v_mixed  = 25'b10110_01001_10110_10110_01001;
    v_nodiag = 25'h0FFFFFF;

    $display("[TB] reset");
    repeat (3) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    resetn = 1'b1;

    $display("[TB] single mixed sample a..e = 1,0,1,1,0");
    apply_stimulus(1'b1, v_mixed, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    set_lit(13, 3, 1, 0, 0, 0, 0, 1, -1);

    $display("[TB] five unanimous samples");
    for (int k = 0; k < 7; k++) begin
      apply_stimulus(k < 5, '1, 1'b1, 1'b0);
      if (k >= 2) set_lit(25, 5, 1, 1, k - 1, int'((k - 1) >= THRESH), k - 1, 1, -1);
    end

    $display("[TB] diagonal bit cleared");
    apply_stimulus(1'b1, v_nodiag, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    set_lit(24, 4, 0, 0, 0, 0, 0, 1, -1);

    $display("[TB] streak saturation");
    for (int k = 0; k < 13; k++) begin
      apply_stimulus(k <= 10, (k < 10) ? 25'h1FFFFFF : v_nodiag, 1'b1, 1'b0);
      if (k >= 2 && k <= 11) set_lit(25, 5, 1, 1, k - 1, int'((k - 1) >= THRESH),
                                     sat(k - 1, 7), 1, -1);
      if (k == 12) set_lit(24, 4, 0, 0, 0, 0, 0, 1, -1);
    end

    $display("[TB] backpressure");
    apply_stimulus(1'b1, '1, 1'b1, 1'b0);
    apply_stimulus(1'b1, v_mixed, 1'b1, 1'b0);
    for (int k = 2; k < 5; k++) begin
      apply_stimulus(1'b1, v_nodiag, 1'b0, 1'b0);
      set_lit(25, 5, 1, 1, 1, 0, 1, 1, 0);
    end
    apply_stimulus(1'b1, v_nodiag, 1'b1, 1'b0);
    set_lit(25, 5, 1, 1, 1, 0, 1, 1, 1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    set_lit(13, 3, 1, 0, 0, 0, 0, 1, -1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    set_lit(24, 4, 0, 0, 0, 0, 0, 1, -1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    set_lit(-1, -1, -1, -1, 0, 0, 0, 0, -1);

    $display("[TB] clear with streak at 3");
    for (int k = 0; k < 4; k++) apply_stimulus(1'b1, '1, 1'b1, 1'b0);
    apply_stimulus(1'b1, v_nodiag, 1'b1, 1'b1);
    set_lit(25, 5, 1, 1, 3, 0, 3, 1, -1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b0, '0, 1'b1, 1'b0);
      set_lit(-1, -1, -1, -1, 0, 0, 0, 0, -1);
    end

    $display("[TB] asynchronous reset mid-stream");
    for (int k = 0; k < 3; k++) apply_stimulus(1'b1, '1, 1'b1, 1'b0);
    #1;
    resetn = 1'b0;
    apply_stimulus(1'b1, '1, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    resetn = 1'b1;
    apply_stimulus(1'b1, '1, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    set_lit(25, 5, 1, 1, 1, 0, 1, 1, -1);

    $display("[TB] randomized stream");
    for (int c = 0; c < 3000; c++) begin
      apply_stimulus($urandom_range(0, 3) != 0, rand_vec(),
                     $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end
    repeat (4) apply_stimulus(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
